// File: rtl/multicycle_pkg.sv
// multicycle_pkg: shared encodings for the multi-cycle control FSM.
// States, RegWrite/ALU/ResultSrc codes, cond and opcode fields.
package multicycle_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_EXEC_DP = 4'd2,
    S_MEMADDR = 4'd3,
    S_MEMRD   = 4'd4,
    S_MEMWR   = 4'd5,
    S_WB      = 4'd6,
    S_BRANCH  = 4'd7,
    S_PCUPD   = 4'd8,
    S_FAULT   = 4'd9
  } state_t;

  localparam logic [1:0] RW_IDLE = 2'b10;
  localparam logic [1:0] RW_RD   = 2'b11;
  localparam logic [1:0] RW_PC   = 2'b00;
  localparam logic [1:0] RW_LINK = 2'b01;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_ORR = 3'b011;
  localparam logic [2:0] ALU_MOV = 3'b100;
  localparam logic [2:0] ALU_EOR = 3'b101;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_UND = 2'b11;

  localparam logic [3:0] DP_AND = 4'b0000;
  localparam logic [3:0] DP_EOR = 4'b0001;
  localparam logic [3:0] DP_SUB = 4'b0010;
  localparam logic [3:0] DP_ADD = 4'b0100;
  localparam logic [3:0] DP_CMP = 4'b1010;
  localparam logic [3:0] DP_ORR = 4'b1100;
  localparam logic [3:0] DP_MOV = 4'b1101;

  typedef struct packed {
    logic       ok;
    logic       cmp;
    logic [2:0] alu;
  } dp_dec_t;

  function automatic dp_dec_t dp_decode(
    input logic [3:0] opc
  );
    dp_dec_t d;
    d.ok  = 1'b1;
    d.cmp = 1'b0;
    d.alu = ALU_ADD;
    case (opc)
      DP_ADD: d.alu = ALU_ADD;
      DP_SUB: d.alu = ALU_SUB;
      DP_CMP: begin
        d.alu = ALU_SUB;
        d.cmp = 1'b1;
      end
      DP_AND: d.alu = ALU_AND;
      DP_ORR: d.alu = ALU_ORR;
      DP_MOV: d.alu = ALU_MOV;
      DP_EOR: d.alu = ALU_EOR;
      default: d.ok = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/cond_check.sv
// cond_check: ARM condition field against NZCV.
// Pure combinational; 1111 is reported as undefined.
module cond_check
  import multicycle_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass,
  output logic       undef
);

  logic n, z, c, v;
  logic ge;

  assign n  = flags[3];
  assign z  = flags[2];
  assign c  = flags[1];
  assign v  = flags[0];
  assign ge = (n == v);

  // Evaluate the condition mnemonic
  always_comb begin
    pass  = 1'b0;
    undef = 1'b0;
    unique case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = ~z;
      COND_CS: pass = c;
      COND_CC: pass = ~c;
      COND_MI: pass = n;
      COND_PL: pass = ~n;
      COND_VS: pass = v;
      COND_VC: pass = ~v;
      COND_HI: pass = c & ~z;
      COND_LS: pass = ~c | z;
      COND_GE: pass = ge;
      COND_LT: pass = ~ge;
      COND_GT: pass = ~z & ge;
      COND_LE: pass = z | ~ge;
      COND_AL: pass = 1'b1;
      COND_NV: undef = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: fetch/decode/exec/mem/wb sequencer.
// Drives regfile write codes, ALU selects and memory handshake.
module multicycle_ctrl
  import multicycle_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] Instr,
  input  logic [3:0]  Flags,
  input  logic        MemReady,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        AdrSrc,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        PCSrc,
  output logic [1:0]  RegWrite,
  output logic [1:0]  ResultSrc,
  output logic        ALUSrcB,
  output logic [2:0]  ALUControl,
  output logic        FlagsWrite,
  output logic        Fault,
  output logic [3:0]  State
);

  localparam logic [15:0] TO = 16'(MEM_TIMEOUT);

  state_t      state;
  state_t      state_next;
  logic [15:0] wait_cnt;
  logic        timeout_hit;
  logic        mem_state;
  logic        cond_pass;
  logic        cond_undef;
  dp_dec_t     dp;
  logic        unused_bits;

  assign unused_bits = ^Instr[19:0];

  cond_check u_cond (
    .cond  (Instr[31:28]),
    .flags (Flags),
    .pass  (cond_pass),
    .undef (cond_undef)
  );

  assign dp = dp_decode(Instr[24:21]);

  assign mem_state = (state == S_FETCH)
                   | (state == S_MEMRD)
                   | (state == S_MEMWR);

  // Wait counter expires on the MEM_TIMEOUT-th idle cycle
  assign timeout_hit = (TO != 16'd0)
                     & (wait_cnt >= TO - 16'd1);

  // State register and saturating wait counter
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
    end else begin
      state <= state_next;
      if (state_next != state)
        wait_cnt <= '0;
      else if (mem_state && !MemReady &&
               wait_cnt != 16'hFFFF)
        wait_cnt <= wait_cnt + 16'd1;
    end
  end

  // Next-state and control outputs
  always_comb begin
    state_next = state;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    AdrSrc     = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    PCSrc      = 1'b0;
    RegWrite   = RW_IDLE;
    ResultSrc  = RES_ALU;
    ALUSrcB    = 1'b0;
    ALUControl = ALU_ADD;
    FlagsWrite = 1'b0;
    Fault      = 1'b0;

    unique case (state)
      S_FETCH: begin
        MemRead = 1'b1;
        if (MemReady) begin
          IRWrite    = 1'b1;
          state_next = S_DECODE;
        end else if (timeout_hit) begin
          state_next = S_FAULT;
        end
      end
      S_DECODE: begin
        if (cond_undef)
          state_next = S_FAULT;
        else if (!cond_pass)
          state_next = S_PCUPD;
        else begin
          unique case (Instr[27:26])
            OP_DP:  state_next = S_EXEC_DP;
            OP_MEM: state_next = S_MEMADDR;
            OP_BR:  state_next = S_BRANCH;
            OP_UND: state_next = S_FAULT;
          endcase
        end
      end
      S_EXEC_DP: begin
        if (!dp.ok) begin
          state_next = S_FAULT;
        end else begin
          ALUSrcB    = Instr[25];
          ALUControl = dp.alu;
          FlagsWrite = Instr[20] | dp.cmp;
          state_next = dp.cmp ? S_PCUPD : S_WB;
        end
      end
      S_MEMADDR: begin
        ALUControl = ALU_ADD;
        ALUSrcB    = 1'b1;
        state_next = Instr[20] ? S_MEMRD
                               : S_MEMWR;
      end
      S_MEMRD: begin
        AdrSrc  = 1'b1;
        MemRead = 1'b1;
        if (MemReady)
          state_next = S_WB;
        else if (timeout_hit)
          state_next = S_FAULT;
      end
      S_MEMWR: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        if (MemReady)
          state_next = S_PCUPD;
        else if (timeout_hit)
          state_next = S_FAULT;
      end
      S_WB: begin
        RegWrite   = RW_RD;
        PCWrite    = 1'b1;
        ResultSrc  = (Instr[27:26] == OP_MEM)
                   ? RES_MEM : RES_ALU;
        state_next = S_FETCH;
      end
      S_BRANCH: begin
        PCWrite    = 1'b1;
        PCSrc      = 1'b1;
        RegWrite   = Instr[24] ? RW_LINK : RW_PC;
        state_next = S_FETCH;
      end
      S_PCUPD: begin
        RegWrite   = RW_PC;
        PCWrite    = 1'b1;
        state_next = S_FETCH;
      end
      S_FAULT: begin
        Fault = 1'b1;
      end
      default: state_next = S_FAULT;
    endcase

    // Reset silences every strobe in the cycle it is seen
    if (RESET) begin
      state_next = S_FETCH;
      MemRead    = 1'b0;
      MemWrite   = 1'b0;
      AdrSrc     = 1'b0;
      IRWrite    = 1'b0;
      PCWrite    = 1'b0;
      PCSrc      = 1'b0;
      RegWrite   = RW_IDLE;
      ResultSrc  = RES_ALU;
      ALUSrcB    = 1'b0;
      ALUControl = ALU_ADD;
      FlagsWrite = 1'b0;
      Fault      = 1'b0;
    end
  end

  assign State = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed per-cycle scoreboard bench.
// Stimulus queues expected outputs; a monitor pops at negedge.
module tb_multicycle_ctrl;
  import multicycle_pkg::*;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [31:0] Instr = 32'hE0821003;
  logic [3:0]  Flags = 4'b0000;
  logic        MemReady = 1'b0;
  logic        MemRead, MemWrite, AdrSrc, IRWrite;
  logic        PCWrite, PCSrc, ALUSrcB, FlagsWrite;
  logic        Fault;
  logic [1:0]  RegWrite, ResultSrc;
  logic [2:0]  ALUControl;
  logic [3:0]  State;

  multicycle_ctrl #(.MEM_TIMEOUT(15)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .Instr      (Instr),
    .Flags      (Flags),
    .MemReady   (MemReady),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .AdrSrc     (AdrSrc),
    .IRWrite    (IRWrite),
    .PCWrite    (PCWrite),
    .PCSrc      (PCSrc),
    .RegWrite   (RegWrite),
    .ResultSrc  (ResultSrc),
    .ALUSrcB    (ALUSrcB),
    .ALUControl (ALUControl),
    .FlagsWrite (FlagsWrite),
    .Fault      (Fault),
    .State      (State)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [3:0] st;
    logic       mr;
    logic       mw;
    logic       adr;
    logic       irw;
    logic       pcw;
    logic       pcs;
    logic [1:0] rw;
    logic [1:0] rs;
    logic       srcb;
    logic [2:0] alu;
    logic       fw;
    logic       flt;
  } exp_t;

  typedef struct {
    exp_t  e;
    string nm;
  } sb_t;

  sb_t sbq[$];
  int  tests = 0;
  int  fails = 0;

  function automatic exp_t mk(input state_t s);
    exp_t e;
    e    = '0;
    e.st = s;
    e.rw = RW_IDLE;
    return e;
  endfunction

  function automatic exp_t e_fetch(input logic rdy);
    exp_t e;
    e     = mk(S_FETCH);
    e.mr  = 1'b1;
    e.irw = rdy;
    return e;
  endfunction

  function automatic exp_t e_exec(
    input logic srcb, input logic [2:0] alu,
    input logic fw
  );
    exp_t e;
    e      = mk(S_EXEC_DP);
    e.srcb = srcb;
    e.alu  = alu;
    e.fw   = fw;
    return e;
  endfunction

  function automatic exp_t e_maddr();
    exp_t e;
    e      = mk(S_MEMADDR);
    e.srcb = 1'b1;
    e.alu  = ALU_ADD;
    return e;
  endfunction

  function automatic exp_t e_mrd();
    exp_t e;
    e     = mk(S_MEMRD);
    e.adr = 1'b1;
    e.mr  = 1'b1;
    return e;
  endfunction

  function automatic exp_t e_mwr();
    exp_t e;
    e     = mk(S_MEMWR);
    e.adr = 1'b1;
    e.mw  = 1'b1;
    return e;
  endfunction

  function automatic exp_t e_wb(input logic [1:0] rs);
    exp_t e;
    e     = mk(S_WB);
    e.rw  = RW_RD;
    e.pcw = 1'b1;
    e.rs  = rs;
    return e;
  endfunction

  function automatic exp_t e_br(input logic [1:0] rw);
    exp_t e;
    e     = mk(S_BRANCH);
    e.pcw = 1'b1;
    e.pcs = 1'b1;
    e.rw  = rw;
    return e;
  endfunction

  function automatic exp_t e_pcu();
    exp_t e;
    e     = mk(S_PCUPD);
    e.rw  = RW_PC;
    e.pcw = 1'b1;
    return e;
  endfunction

  function automatic exp_t e_flt();
    exp_t e;
    e     = mk(S_FAULT);
    e.flt = 1'b1;
    return e;
  endfunction

  task automatic cyc(
    input exp_t e, input logic rdy,
    input logic rst, input string nm
  );
    sb_t t;
    t.e      = e;
    t.nm     = nm;
    MemReady = rdy;
    RESET    = rst;
    sbq.push_back(t);
    @(posedge CLK);
    #1;
  endtask

  // Monitor: compare one queued expectation per cycle
  initial begin
    sb_t  t;
    exp_t g;
    forever begin
      @(negedge CLK);
      if (sbq.size() != 0) begin
        t = sbq.pop_front();
        g.st   = State;
        g.mr   = MemRead;
        g.mw   = MemWrite;
        g.adr  = AdrSrc;
        g.irw  = IRWrite;
        g.pcw  = PCWrite;
        g.pcs  = PCSrc;
        g.rw   = RegWrite;
        g.rs   = ResultSrc;
        g.srcb = ALUSrcB;
        g.alu  = ALUControl;
        g.fw   = FlagsWrite;
        g.flt  = Fault;
        tests++;
        if (g !== t.e) begin
          fails++;
          $display("FAIL %s got=%h want=%h", t.nm, g, t.e);
          $display("  st=%0d/%0d rw=%b/%b alu=%b/%b",
                   g.st, t.e.st, g.rw, t.e.rw,
                   g.alu, t.e.alu);
        end
      end
    end
  end

  task automatic run_add(input logic [31:0] ins,
                         input logic srcb,
                         input logic [2:0] alu,
                         input logic fw,
                         input string nm);
    Instr = ins;
    cyc(e_fetch(1), 1, 0, {nm, ".fetch"});
    cyc(mk(S_DECODE), 0, 0, {nm, ".dec"});
    cyc(e_exec(srcb, alu, fw), 0, 0, {nm, ".exec"});
    cyc(e_wb(RES_ALU), 0, 0, {nm, ".wb"});
  endtask

  initial begin
    @(posedge CLK);
    #1;
    cyc(mk(S_FETCH), 1, 1, "reset0");
    cyc(mk(S_FETCH), 0, 1, "reset1");

    run_add(32'hE0821003, 0, ALU_ADD, 0, "add");
    run_add(32'hE3A01005, 1, ALU_MOV, 0, "movi");
    run_add(32'hE0311002, 0, ALU_EOR, 1, "eors");

    Instr = 32'hE5954000;
    cyc(e_fetch(1), 1, 0, "ldr.fetch");
    cyc(mk(S_DECODE), 0, 0, "ldr.dec");
    cyc(e_maddr(), 1, 0, "ldr.addr");
    for (int i = 0; i < 3; i++)
      cyc(e_mrd(), 0, 0, "ldr.wait");
    cyc(e_mrd(), 1, 0, "ldr.rd");
    cyc(e_wb(RES_MEM), 0, 0, "ldr.wb");

    Instr = 32'hE5854000;
    cyc(e_fetch(1), 1, 0, "str.fetch");
    cyc(mk(S_DECODE), 0, 0, "str.dec");
    cyc(e_maddr(), 0, 0, "str.addr");
    cyc(e_mwr(), 1, 0, "str.wr");
    cyc(e_pcu(), 0, 0, "str.pcupd");

    Instr = 32'hE1510002;
    cyc(e_fetch(1), 1, 0, "cmp.fetch");
    cyc(mk(S_DECODE), 0, 0, "cmp.dec");
    cyc(e_exec(0, ALU_SUB, 1), 0, 0, "cmp.exec");
    cyc(e_pcu(), 0, 0, "cmp.pcupd");

    Instr = 32'hEB000004;
    cyc(e_fetch(1), 1, 0, "bl.fetch");
    cyc(mk(S_DECODE), 0, 0, "bl.dec");
    cyc(e_br(RW_LINK), 0, 0, "bl.br");
    Instr = 32'hEA000004;
    cyc(e_fetch(1), 1, 0, "b.fetch");
    cyc(mk(S_DECODE), 0, 0, "b.dec");
    cyc(e_br(RW_PC), 0, 0, "b.br");

    Instr = 32'h00821003;
    Flags = 4'b0000;
    cyc(e_fetch(1), 1, 0, "addeq0.fetch");
    cyc(mk(S_DECODE), 0, 0, "addeq0.dec");
    cyc(e_pcu(), 0, 0, "addeq0.pcupd");
    Flags = 4'b0100;
    run_add(32'h00821003, 0, ALU_ADD, 0, "addeq1");
    Instr = 32'hC0821003;
    Flags = 4'b1000;
    cyc(e_fetch(1), 1, 0, "addgt.fetch");
    cyc(mk(S_DECODE), 0, 0, "addgt.dec");
    cyc(e_pcu(), 0, 0, "addgt.pcupd");
    Flags = 4'b0000;

    Instr = 32'hE5954000;
    cyc(e_fetch(1), 1, 0, "ldrr.fetch");
    cyc(mk(S_DECODE), 0, 0, "ldrr.dec");
    cyc(e_maddr(), 0, 0, "ldrr.addr");
    cyc(e_mrd(), 0, 0, "ldrr.wait");
    cyc(mk(S_MEMRD), 0, 1, "ldrr.rst");
    run_add(32'hE0821003, 0, ALU_ADD, 0, "add2");

    Instr = 32'hF0821003;
    cyc(e_fetch(1), 1, 0, "nv.fetch");
    cyc(mk(S_DECODE), 0, 0, "nv.dec");
    cyc(e_flt(), 1, 0, "nv.fault");
    cyc(mk(S_FAULT), 0, 1, "nv.rst");

    Instr = 32'hE1300000;
    cyc(e_fetch(1), 1, 0, "teq.fetch");
    cyc(mk(S_DECODE), 0, 0, "teq.dec");
    cyc(mk(S_EXEC_DP), 0, 0, "teq.exec");
    cyc(e_flt(), 0, 0, "teq.fault");
    cyc(mk(S_FAULT), 0, 1, "teq.rst");

    Instr = 32'hEC000000;
    cyc(e_fetch(1), 1, 0, "op11.fetch");
    cyc(mk(S_DECODE), 0, 0, "op11.dec");
    cyc(e_flt(), 0, 0, "op11.fault");
    cyc(mk(S_FAULT), 0, 1, "op11.rst");

    Instr = 32'hE0821003;
    for (int i = 0; i < 15; i++)
      cyc(e_fetch(0), 0, 0, "to.wait");
    cyc(e_flt(), 1, 0, "to.fault0");
    cyc(e_flt(), 1, 0, "to.fault1");
    cyc(e_flt(), 0, 0, "to.fault2");
    cyc(mk(S_FAULT), 0, 1, "to.rst");
    cyc(e_fetch(0), 0, 0, "to.after");
    cyc(e_fetch(1), 1, 0, "to.fetch");
    cyc(mk(S_DECODE), 0, 0, "to.dec");

    for (int i = 0; i < 10 && sbq.size() != 0; i++)
      @(negedge CLK);
    if (sbq.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain left=%0d want=0", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multi-cycle control FSM that sequences the 16x32 register file and shared instruction/data memory port for the ARM-subset core. Walks each instruction through fetch, decode, execute, memory and writeback. Emits the 2-bit RegWrite code, ALU/mux selects and memory handshake. Sits beside the register file in the core top, fed by the instruction register and the NZCV flag register.

Parameters:
MEM_TIMEOUT, 15, max cycles waiting on MemReady before entering S_FAULT (0 disables timeout)

Ports:
CLK  input  1  core clock
RESET  input  1  synchronous, active-high reset
Instr  input  32  instruction register contents (valid from S_DECODE onward)
Flags  input  4  NZCV from flag register
MemReady  input  1  memory completes current access this cycle
MemRead  output  1  memory read request; held until MemReady
MemWrite  output  1  memory write request; held until MemReady
AdrSrc  output  1  0 = PC addresses memory, 1 = ALU result register
IRWrite  output  1  load instruction register
PCWrite  output  1  advance PC (PC+4 or branch target)
PCSrc  output  1  0 = PC+4, 1 = branch target
RegWrite  output  2  register-file write code: 10 idle/read, 11 write RA3<=WD3, 00 R15<=PC+8, 01 R15<=PC+8 and R14<=PC+4
ResultSrc  output  2  WD3 select: 00 ALU, 01 memory data, 10 PC+4
ALUSrcB  output  1  0 = RD2, 1 = extended immediate
ALUControl  output  3  000 ADD, 001 SUB, 010 AND, 011 ORR, 100 MOV, 101 EOR
FlagsWrite  output  1  update NZCV at end of EXEC
Fault  output  1  sticky; set on MemReady timeout or undefined op
State  output  4  current state, debug

Behaviour:
- Reset: state S_FETCH; all strobes 0; RegWrite=10; selects 0; Fault=0. RESET mid-access drops MemRead/MemWrite next cycle, no writeback issued.
- States: S_FETCH, S_DECODE, S_EXEC_DP, S_MEMADDR, S_MEMRD, S_MEMWR, S_WB, S_BRANCH, S_PCUPD, S_FAULT.
- S_FETCH: MemRead=1, AdrSrc=0. On MemReady: IRWrite=1 same cycle -> S_DECODE. Else stay; wait counter increments.
- S_DECODE: cond (Instr[31:28]) evaluated against Flags (EQ,NE,CS,CC,MI,PL,VS,VC,HI,LS,GE,LT,GT,LE,AL; 1111 undefined -> S_FAULT). Cond fail -> S_PCUPD. Instr[27:26]: 00 -> S_EXEC_DP, 01 -> S_MEMADDR, 10 -> S_BRANCH, 11 -> S_FAULT.
- S_EXEC_DP: ALUSrcB=Instr[25]; ALUControl from Instr[24:21] (0100 ADD, 0010 SUB, 1010 CMP=SUB, 0000 AND, 1100 ORR, 1101 MOV, 0001 EOR; others -> S_FAULT). FlagsWrite=Instr[20] (forced 1 for CMP). CMP -> S_PCUPD; otherwise -> S_WB.
- S_MEMADDR: ALUControl=ADD, ALUSrcB=1. Instr[20]=1 -> S_MEMRD, else S_MEMWR.
- S_MEMRD/S_MEMWR: AdrSrc=1, request held until MemReady. MEMRD -> S_WB with ResultSrc=01; MEMWR -> S_PCUPD.
- S_WB: RegWrite=11 for exactly one cycle, PCWrite=1, PCSrc=0 -> S_FETCH.
- S_BRANCH: PCWrite=1, PCSrc=1; RegWrite=01 if Instr[24] (BL), else 00 -> S_FETCH.
- S_PCUPD: RegWrite=00, PCWrite=1, PCSrc=0 -> S_FETCH.
- RegWrite is 10 in every state not listed above; any code other than 10 is asserted for exactly one cycle per instruction (regfile samples on posedge, writes on negedge).
- Timeout: wait counter clears on state entry; reaching MEM_TIMEOUT in S_FETCH/S_MEMRD/S_MEMWR -> S_FAULT. Counter saturates, no wrap.
- S_FAULT: absorbing until RESET; all strobes 0, Fault=1.
- MemReady outside memory states is ignored. MemRead and MemWrite never both 1.
- Latencies (MemReady immediate): DP 4 cycles, CMP 4, LDR 5, STR 5, B/BL 3, cond-fail 3.

Decomposition:
- Package multicycle_pkg: state encoding, RegWrite codes (RW_IDLE=10, RW_RD=11, RW_PC=00, RW_LINK=01), ALUControl codes, ResultSrc codes, cond-field constants.
- Sub-module cond_check: combinational Instr[31:28] x Flags -> pass, undefined.

Test Plan:
- ADD R1,R2,R3 (0xE0821003), MemReady immediate -> FETCH,DECODE,EXEC_DP,WB; RegWrite=11 only in WB; ALUControl=000; FlagsWrite=0.
- LDR R4,[R5] (0xE5954000), MemReady 3 cycles late in MEMRD -> MemRead held 3 cycles; WB ResultSrc=01, RegWrite=11; total 8 cycles.
- BL (0xEB000004) -> BRANCH with RegWrite=01, PCSrc=1, PCWrite=1; B (0xEA000004) -> RegWrite=00.
- ADDEQ (0x00821003), Flags=0000 -> S_PCUPD, RegWrite=00, no 11 issued; with Flags=0100 -> normal DP path.
- CMP R1,R2 (0xE1510002) -> ALUControl=001, FlagsWrite=1, no RegWrite=11; STR (0xE5854000) -> MemWrite, AdrSrc=1, no 11.
- MemReady low 15 cycles in FETCH -> S_FAULT, Fault=1 sticky; RESET mid-fault -> S_FETCH, Fault=0, RegWrite=10 next cycle.
